// File: rtl/gray_counter_sync.sv
// Fully synchronous up/down Gray-code counter with parallel Gray load,
// wrap or saturate at terminal count, and a sticky overflow flag.
module gray_counter_sync #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             ovf_q, ovf_d;
  logic             tc;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] bv;
    bv[WIDTH-1] = gv[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

  assign tc = (UP && (b_q == ALL_ONES)) || (!UP && (b_q == ZERO));

  always_comb begin
    b_d   = b_q;
    g_d   = g_q;
    ovf_d = ovf_q;
    if (LD) begin
      b_d   = gray2bin(D);
      g_d   = D;
      ovf_d = 1'b0;
    end else if (EN) begin
      if (tc) begin
        ovf_d = 1'b1;
        // Saturate mode leaves b_d at b_q, so the Gray code holds as well.
        if (WRAP) begin
          b_d = UP ? ZERO : ALL_ONES;
        end
      end else begin
        b_d = UP ? (b_q + ONE) : (b_q - ONE);
      end
      g_d = b_d ^ (b_d >> 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      b_q   <= ZERO;
      g_q   <= ZERO;
      ovf_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      g_q   <= g_d;
      ovf_q <= ovf_d;
    end
  end

  assign G   = g_q;
  assign B   = b_q;
  assign TC  = tc;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_gray_counter_sync.sv
// Scoreboard bench for gray_counter_sync: four instances covering wrap,
// saturate and two other widths; expected states queue up, a monitor checks.
module tb_gray_counter_sync;

  logic clk;
  logic rst [4];
  logic en  [4];
  logic up  [4];
  logic ld  [4];
  logic tc  [4];
  logic ovf [4];

  logic [3:0] d_w4, g_w4, b_w4;
  logic [3:0] d_s4, g_s4, b_s4;
  logic [1:0] d_w2, g_w2, b_w2;
  logic [7:0] d_w8, g_w8, b_w8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         inst;
    logic [7:0] g;
    logic [7:0] b;
    logic       tc;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_counter_sync #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .CLK(clk), .RST(rst[0]), .EN(en[0]), .UP(up[0]), .LD(ld[0]), .D(d_w4),
    .G(g_w4), .B(b_w4), .TC(tc[0]), .OVF(ovf[0]));

  gray_counter_sync #(.WIDTH(4), .WRAP(1'b0)) u_s4 (
    .CLK(clk), .RST(rst[1]), .EN(en[1]), .UP(up[1]), .LD(ld[1]), .D(d_s4),
    .G(g_s4), .B(b_s4), .TC(tc[1]), .OVF(ovf[1]));

  gray_counter_sync #(.WIDTH(2), .WRAP(1'b1)) u_w2 (
    .CLK(clk), .RST(rst[2]), .EN(en[2]), .UP(up[2]), .LD(ld[2]), .D(d_w2),
    .G(g_w2), .B(b_w2), .TC(tc[2]), .OVF(ovf[2]));

  gray_counter_sync #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .CLK(clk), .RST(rst[3]), .EN(en[3]), .UP(up[3]), .LD(ld[3]), .D(d_w8),
    .G(g_w8), .B(b_w8), .TC(tc[3]), .OVF(ovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_g(int i);
    case (i)
      0:       return {4'b0, g_w4};
      1:       return {4'b0, g_s4};
      2:       return {6'b0, g_w2};
      default: return g_w8;
    endcase
  endfunction

  function automatic logic [7:0] obs_b(int i);
    case (i)
      0:       return {4'b0, b_w4};
      1:       return {4'b0, b_s4};
      2:       return {6'b0, b_w2};
      default: return b_w8;
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so every queued expectation is checked here.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] ag, ab;
      e  = sb.pop_front();
      ag = obs_g(e.inst);
      ab = obs_b(e.inst);
      total++;
      if (ag !== e.g || ab !== e.b || tc[e.inst] !== e.tc || ovf[e.inst] !== e.ovf) begin
        bad++;
        $display("FAIL %s inst=%0d got G=%b B=%0d TC=%b OVF=%b want G=%b B=%0d TC=%b OVF=%b",
                 e.tag, e.inst, ag, ab, tc[e.inst], ovf[e.inst], e.g, e.b, e.tc, e.ovf);
      end
    end
  end

  task automatic push(int i, logic [7:0] eg, logic [7:0] eb, logic etc, logic eovf, string tag);
    exp_t e;
    e.inst = i; e.g = eg; e.b = eb; e.tc = etc; e.ovf = eovf; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_one_bit(int i, logic [7:0] gprev, string tag);
    logic [7:0] gnow;
    gnow = obs_g(i);
    total++;
    if ($countones(gnow ^ gprev) != 1) begin
      bad++;
      $display("FAIL %s inst=%0d G %b -> %b changed %0d bits, want 1",
               tag, i, gprev, gnow, $countones(gnow ^ gprev));
    end
  endtask

  task automatic sweep(int i, int w);
    int n;
    logic [7:0] mask, bb, gp;
    n    = 1 << w;
    mask = 8'(n - 1);
    rst[i] = 1'b1; en[i] = 1'b0; ld[i] = 1'b0; up[i] = 1'b1;
    cyc();
    push(i, 8'd0, 8'd0, 1'b0, 1'b0, "sweep_rst");
    settle();
    rst[i] = 1'b0; en[i] = 1'b1;
    gp = 8'd0;
    for (int k = 1; k <= n; k++) begin
      cyc();
      bb = 8'(k % n);
      push(i, bb ^ (bb >> 1), bb, bb == mask, k == n, "sweep_step");
      check_one_bit(i, gp, "sweep_onebit");
      gp = obs_g(i);
      settle();
    end
    en[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] gp;
    logic [3:0] kb;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b1; ld[i] = 1'b0;
    end
    d_w4 = '0; d_s4 = '0; d_w2 = '0; d_w8 = '0;

    // Reset, then a full up count with wrap
    cyc(); cyc();
    push(0, 8'h00, 8'd0, 1'b0, 1'b0, "reset_state");
    settle();
    rst[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    gp = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      kb = 4'(k % 16);
      push(0, {4'b0, gtab[kb]}, {4'b0, kb}, kb == 4'd15, k == 16, "count_up");
      check_one_bit(0, gp, "up_onebit");
      gp = obs_g(0);
      settle();
    end

    // Underflow with wrap
    rst[0] = 1'b1; en[0] = 1'b0;
    cyc();
    push(0, 8'h00, 8'd0, 1'b0, 1'b0, "reset_clears_ovf");
    settle();
    rst[0] = 1'b0; up[0] = 1'b0;
    push(0, 8'h00, 8'd0, 1'b1, 1'b0, "tc_at_zero_down");
    settle();
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    push(0, 8'b1000, 8'd15, 1'b0, 1'b1, "underflow_wrap");
    settle();

    // Saturate mode
    rst[1] = 1'b0; up[1] = 1'b1; ld[1] = 1'b1; d_s4 = 4'b1000;
    cyc();
    ld[1] = 1'b0;
    push(1, 8'b1000, 8'd15, 1'b1, 1'b0, "sat_load");
    settle();
    en[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      push(1, 8'b1000, 8'd15, 1'b1, 1'b1, "sat_hold");
      settle();
    end
    up[1] = 1'b0;
    cyc();
    en[1] = 1'b0;
    push(1, 8'b1001, 8'd14, 1'b0, 1'b1, "sat_down");
    settle();

    // Load beats enable and clears OVF
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0; up[0] = 1'b1; ld[0] = 1'b1; d_w4 = 4'b1000;
    cyc();
    ld[0] = 1'b0; en[0] = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    en[0] = 1'b0;
    push(0, 8'b0111, 8'd5, 1'b0, 1'b1, "pre_load_state");
    settle();
    ld[0] = 1'b1; en[0] = 1'b1; d_w4 = 4'b1101;
    cyc();
    ld[0] = 1'b0;
    push(0, 8'b1101, 8'd9, 1'b0, 1'b0, "load_priority");
    settle();
    cyc();
    en[0] = 1'b0;
    push(0, 8'b1111, 8'd10, 1'b0, 1'b0, "step_after_load");
    settle();

    // Reset beats load mid-count
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    push(0, 8'b0100, 8'd7, 1'b0, 1'b0, "count_to_7");
    settle();
    rst[0] = 1'b1; ld[0] = 1'b1; d_w4 = 4'b1111;
    cyc();
    rst[0] = 1'b0; ld[0] = 1'b0; en[0] = 1'b0;
    push(0, 8'h00, 8'd0, 1'b0, 1'b0, "reset_priority");
    settle();

    // Hold at all-ones while UP toggles: TC follows UP
    ld[0] = 1'b1; d_w4 = 4'b1000;
    cyc();
    ld[0] = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      up[0] = ~up[0];
      d_w4  = 4'(k * 3 + 1);
      cyc();
      push(0, 8'b1000, 8'd15, up[0], 1'b0, "hold_tc_tracks_up");
      settle();
    end

    // Width sweep
    sweep(2, 2);
    sweep(3, 8);

    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
